// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared encodings and types for the RV32I-subset decode stage:
//             opcode/funct3/funct7 constants, ALU control enum, the packed
//             control bundle and the control decoder function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    // Major opcodes of the supported subset
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_F3_ADD = 3'b000;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_SW  = 3'b010;
    localparam logic [2:0] c_F3_BNE = 3'b001;

    localparam logic [6:0] c_F7_ADD = 7'b0000000;
    localparam logic [6:0] c_F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001
    } alu_ctrl_t;

    typedef struct packed {
        alu_ctrl_t alu_ctrl;
        logic      alu_src;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch_ne;
        logic      illegal;
    } ctrl_t;

    // Starts from "illegal" and clears it only on a fully matched encoding,
    // so every unlisted opcode/funct combination falls out as illegal with
    // all side-effecting controls low.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        ctrl_t c;
        c           = '0;
        c.alu_ctrl  = ALU_ADD;
        c.illegal   = 1'b1;
        case (opcode)
            c_OP_IMM: begin
                if (funct3 == c_F3_ADD) begin
                    c.alu_src   = 1'b1;
                    c.reg_write = 1'b1;
                    c.illegal   = 1'b0;
                end
            end
            c_OP_REG: begin
                if (funct3 == c_F3_ADD && funct7 == c_F7_ADD) begin
                    c.reg_write = 1'b1;
                    c.illegal   = 1'b0;
                end else if (funct3 == c_F3_ADD && funct7 == c_F7_SUB) begin
                    c.alu_ctrl  = ALU_SUB;
                    c.reg_write = 1'b1;
                    c.illegal   = 1'b0;
                end
            end
            c_OP_LOAD: begin
                if (funct3 == c_F3_LW) begin
                    c.alu_src   = 1'b1;
                    c.mem_read  = 1'b1;
                    c.reg_write = 1'b1;
                    c.illegal   = 1'b0;
                end
            end
            c_OP_STORE: begin
                if (funct3 == c_F3_SW) begin
                    c.alu_src   = 1'b1;
                    c.mem_write = 1'b1;
                    c.illegal   = 1'b0;
                end
            end
            c_OP_BRANCH: begin
                if (funct3 == c_F3_BNE) begin
                    c.alu_ctrl  = ALU_SUB;
                    c.branch_ne = 1'b1;
                    c.illegal   = 1'b0;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_if
//  Purpose  : Bundles the fetch-side input handshake, writeback port and the
//             execute-side output handshake/payload of the decode stage.
//  Ports    : master = fetch/writeback/execute side (drives instr, pc, flush,
//             wb_*, out_ready); slave = decode stage (drives in_ready, out_*).
//  Revision : 1.0  initial release
// ============================================================================
interface decode_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [WIDTH-1:0]      pc;
    logic                  flush;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [WIDTH-1:0]      wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_pc;
    logic [WIDTH-1:0]      rs1_data;
    logic [WIDTH-1:0]      rs2_data;
    logic [WIDTH-1:0]      imm_op;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            alu_ctrl;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch_ne;
    logic                  illegal;

    modport master (
        output in_valid, instr, pc, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, rs1_data, rs2_data, imm_op,
               rd_addr, alu_ctrl, alu_src, reg_write, mem_read, mem_write,
               branch_ne, illegal
    );

    modport slave (
        input  in_valid, instr, pc, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_pc, rs1_data, rs2_data, imm_op,
               rd_addr, alu_ctrl, alu_src, reg_write, mem_read, mem_write,
               branch_ne, illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_reg_file
//  Purpose  : 2**ADDR_WIDTH x WIDTH register file, one synchronous write
//             port and two combinational read ports. x0 reads as zero and a
//             same-cycle write to a read index is forwarded to that read.
//  Ports    : clk, rst (sync, active-low), wb_en/wb_addr/wb_data write port,
//             rs1_addr/rs1_data and rs2_addr/rs2_data read ports.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage_reg_file #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic [WIDTH-1:0]      rs1_data,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [WIDTH-1:0]      rs2_data
);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] r_regs [c_DEPTH];
    logic             w_wr;

    assign w_wr = wb_en && (wb_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // w_wr already excludes x0, so the bypass can never leak a value into x0
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (w_wr && wb_addr == rs1_addr) ? wb_data : r_regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = (w_wr && wb_addr == rs2_addr) ? wb_data : r_regs[rs2_addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV32I-subset decode (addi, add, sub, lw, sw, bne). Reads
//             operands, builds the sign-extended immediate and control word,
//             and hands a one-entry registered bundle to execute over a
//             valid/ready handshake.
//  Ports    : clk, rst (sync, active-low), bus (decode_if.slave): fetch
//             in_valid/in_ready/instr/pc, flush, writeback wb_*, and execute
//             out_valid/out_ready plus decoded payload.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    ctrl_t                 w_ctrl;
    logic [WIDTH-1:0]      w_imm;
    logic [WIDTH-1:0]      w_rs1_data;
    logic [WIDTH-1:0]      w_rs2_data;
    logic                  w_in_ready;
    logic                  w_accept;

    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_pc;
    logic [WIDTH-1:0]      r_rs1_data;
    logic [WIDTH-1:0]      r_rs2_data;
    logic [WIDTH-1:0]      r_imm;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    ctrl_t                 r_ctrl;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];
    assign w_ctrl   = decode_ctrl(w_opcode, w_funct3, w_funct7);

    // Immediate is forced to zero for illegal encodings so a bad instruction
    // can never carry a stray offset downstream.
    always_comb begin
        w_imm = '0;
        if (!w_ctrl.illegal) begin
            case (w_opcode)
                c_OP_IMM, c_OP_LOAD:
                    w_imm = {{(WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
                c_OP_STORE:
                    w_imm = {{(WIDTH-12){bus.instr[31]}}, bus.instr[31:25],
                             bus.instr[11:7]};
                c_OP_BRANCH:
                    w_imm = {{(WIDTH-13){bus.instr[31]}}, bus.instr[31],
                             bus.instr[7], bus.instr[30:25], bus.instr[11:8],
                             1'b0};
                default:
                    w_imm = '0;
            endcase
        end
    end

    decode_stage_reg_file #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (bus.wb_en),
        .wb_addr  (bus.wb_addr),
        .wb_data  (bus.wb_data),
        .rs1_addr (bus.instr[15 +: ADDR_WIDTH]),
        .rs1_data (w_rs1_data),
        .rs2_addr (bus.instr[20 +: ADDR_WIDTH]),
        .rs2_data (w_rs2_data)
    );

    // Ready depends only on the output slot, never on in_valid, so fetch can
    // compute its own valid from ready without a combinational loop.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rd_addr   <= '0;
            r_ctrl      <= '0;
        end else begin
            // Flush wins over both a fresh capture and a held bundle
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_pc       <= bus.pc;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_imm;
                r_rd_addr  <= bus.instr[7 +: ADDR_WIDTH];
                r_ctrl     <= w_ctrl;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_pc;
    assign bus.rs1_data  = r_rs1_data;
    assign bus.rs2_data  = r_rs2_data;
    assign bus.imm_op    = r_imm;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.alu_ctrl  = r_ctrl.alu_ctrl;
    assign bus.alu_src   = r_ctrl.alu_src;
    assign bus.reg_write = r_ctrl.reg_write;
    assign bus.mem_read  = r_ctrl.mem_read;
    assign bus.mem_write = r_ctrl.mem_write;
    assign bus.branch_ne = r_ctrl.branch_ne;
    assign bus.illegal   = r_ctrl.illegal;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. Directed instructions
//             push hand-computed bundles into a scoreboard; a monitor pops
//             and compares on every output handshake.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  alu;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_ne;
        logic        illegal;
    } bundle_t;

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    // flag order: {alu_src, reg_write, mem_read, mem_write, branch_ne, illegal}
    localparam logic [5:0] c_F_ADDI = 6'b110000;
    localparam logic [5:0] c_F_R    = 6'b010000;
    localparam logic [5:0] c_F_LW   = 6'b111000;
    localparam logic [5:0] c_F_SW   = 6'b100100;
    localparam logic [5:0] c_F_BNE  = 6'b000010;
    localparam logic [5:0] c_F_ILL  = 6'b000001;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bundle_t sb[$];

    decode_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

    decode_stage #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [4:0] rd, input logic [2:0] alu,
                                   input logic [5:0] f);
        bundle_t b;
        b = {pc, rs1, rs2, imm, rd, alu, f};
        return b;
    endfunction

    function automatic bundle_t actual();
        bundle_t b;
        b = {bus.out_pc, bus.rs1_data, bus.rs2_data, bus.imm_op, bus.rd_addr,
             bus.alu_ctrl, bus.alu_src, bus.reg_write, bus.mem_read,
             bus.mem_write, bus.branch_ne, bus.illegal};
        return b;
    endfunction

    // rd is don't-care without reg_write; ALU fields are unspecified for illegal
    function automatic bundle_t care_of(input bundle_t e);
        bundle_t c;
        c = '1;
        if (!e.reg_write) c.rd = '0;
        if (e.illegal) begin
            c.alu     = '0;
            c.alu_src = 1'b0;
        end
        return c;
    endfunction

    task automatic check_bundle(input string name, input bundle_t act, input bundle_t exp);
        bundle_t care;
        care = care_of(exp);
        checks++;
        if (((act ^ exp) & care) !== '0) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (care=%h)", name, act, exp, care);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: compare every bundle that execute actually takes
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", actual());
            end else begin
                check_bundle("bundle", actual(), sb.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] p, input bundle_t e);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc       = p;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) sb.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_ready required=ready pc=%h", p);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        @(posedge clk);
        #1;
        bus.wb_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bundle_t e;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.pc        = '0;
        bus.flush     = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        check_bundle("reset_payload", actual(), '0);
        @(posedge clk);
        #1;

        // Every register reads zero after reset: add x0, xi, xi
        for (int i = 1; i < 32; i++) begin
            send((32'(i) << 20) | (32'(i) << 15) | 32'h33, 32'h100 + 32'(i) * 4,
                 mk(32'h100 + 32'(i) * 4, 0, 0, 0, 5'd0, c_ADD, c_F_R));
        end

        // Write to x0 is ignored; addi x1, x0, 5
        wb_write(5'd0, 32'hDEAD);
        send(32'h00500093, 32'h4, mk(32'h4, 0, 0, 5, 5'd1, c_ADD, c_F_ADDI));

        // sub x3, x1, x2 with x2 written in the same cycle (bypass)
        wb_write(5'd1, 32'd7);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd2;
        bus.wb_data = 32'd3;
        send(32'h402081B3, 32'h8, mk(32'h8, 7, 3, 0, 5'd3, c_SUB, c_F_R));
        bus.wb_en   = 1'b0;

        // bne with negative offset -4
        send(32'hFE209EE3, 32'hC, mk(32'hC, 7, 3, 32'hFFFFFFFC, 5'd29, c_SUB, c_F_BNE));
        // lw x5, -8(x1)
        send(32'hFF80A283, 32'h10, mk(32'h10, 7, 0, 32'hFFFFFFF8, 5'd5, c_ADD, c_F_LW));
        // sw x2, 12(x1)
        send(32'h0020A623, 32'h14, mk(32'h14, 7, 3, 32'd12, 5'd12, c_ADD, c_F_SW));
        // sw x2, -1(x1)
        send(32'hFE20AFA3, 32'h18, mk(32'h18, 7, 3, 32'hFFFFFFFF, 5'd31, c_ADD, c_F_SW));
        // add x4, x1, x2
        send(32'h00208233, 32'h1C, mk(32'h1C, 7, 3, 0, 5'd4, c_ADD, c_F_R));
        // illegal opcode and an unsupported funct7 on the R-type opcode
        send(32'h0000007F, 32'h20, mk(32'h20, 0, 0, 0, 5'd0, c_ADD, c_F_ILL));
        send(32'h02208233, 32'h24, mk(32'h24, 7, 3, 0, 5'd4, c_ADD, c_F_ILL));
        idle(2);

        // Flush in the same cycle as an accept discards the new bundle
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00500093;
        bus.pc       = 32'h30;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        check_bit("flush_accept_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Stall for three cycles, then flush the held bundle
        bus.out_ready = 1'b0;
        e = mk(32'h40, 0, 0, 5, 5'd1, c_ADD, c_F_ADDI);
        send(32'h00500093, 32'h40, e);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00208233;
        bus.pc       = 32'h44;
        repeat (3) begin
            @(negedge clk);
            check_bit("stall_in_ready", bus.in_ready, 1'b0);
            check_bit("stall_out_valid", bus.out_valid, 1'b1);
            check_bundle("stall_hold", actual(), e);
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check_bit("flush_out_valid", bus.out_valid, 1'b0);
        check_bit("flush_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Reset while a bundle is held clears it and the register file
        send(32'h00208233, 32'h50, mk(32'h50, 7, 3, 0, 5'd4, c_ADD, c_F_R));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check_bit("midreset_out_valid", bus.out_valid, 1'b0);
        check_bundle("midreset_payload", actual(), '0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'h00208233, 32'h54, mk(32'h54, 0, 0, 0, 5'd4, c_ADD, c_F_R));

        idle(4);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
